// File: rtl/pwm_pkg.sv
// Shared PWM types and defaults, also used by the triangle-wave duty generator.
package pwm_pkg;

   localparam int DUTY_W_DEF = 7;
   localparam int PERIOD_DEF = 64;

   typedef logic [DUTY_W_DEF-1:0] duty_t;

   // Dead-time driver states: both off, high side on, low side on.
   typedef enum logic [1:0] {
      LOW_BOTH  = 2'd0,
      HIGH_SIDE = 2'd1,
      LOW_SIDE  = 2'd2
   } dt_state_e;

   typedef struct packed {
      logic hi;
      logic lo;
   } pwm_pair_t;

endpackage

// File: rtl/pwm_deadtime_ins.sv
// Half-bridge dead-time inserter: turns raw/gate into a non-overlapping output pair.
// Compiled only when PWM_DEADTIME_EN is defined.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime_ins
   import pwm_pkg::*;
#(
   parameter int DEADTIME = 2
) (
   input  logic      sysclk,
   input  logic      reset,
   input  logic      raw,
   input  logic      gate,
   output pwm_pair_t drv
);

   localparam logic [2:0] DT = 3'(DEADTIME);

   dt_state_e  state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       raw_q;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state <= LOW_BOTH;
         cnt   <= '0;
         raw_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         raw_q <= raw;
      end
   end

   // Any raw edge seen while both sides are off restarts the dead-time,
   // so a pulse shorter than DEADTIME never reaches either side.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!gate) begin
         state_nxt = LOW_BOTH;
         cnt_nxt   = '0;
      end else begin
         case (state)
            HIGH_SIDE: if (!raw) begin
               state_nxt = LOW_BOTH;
               cnt_nxt   = 3'd1;
            end
            LOW_SIDE: if (raw) begin
               state_nxt = LOW_BOTH;
               cnt_nxt   = 3'd1;
            end
            default: begin
               if (raw != raw_q)
                  cnt_nxt = 3'd1;
               else if (cnt >= DT)
                  state_nxt = raw ? HIGH_SIDE : LOW_SIDE;
               else
                  cnt_nxt = cnt + 3'd1;
            end
         endcase
      end
   end

   always_comb begin
      drv = '0;
      case (state)
         HIGH_SIDE: drv.hi = 1'b1;
         LOW_SIDE:  drv.lo = 1'b1;
         default:   drv    = '0;
      endcase
   end

endmodule
`endif

// File: rtl/pwm_duty_driver.sv
// Fixed-frequency PWM with period-boundary double-buffered duty and glitch-free enable.
// Define PWM_DEADTIME_EN to drive the complementary pair through a dead-time inserter.
module pwm_duty_driver
   import pwm_pkg::*;
#(
   parameter int PERIOD   = PERIOD_DEF,
   parameter int DUTY_W   = DUTY_W_DEF,
   parameter int DEADTIME = 2
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              Enable_SW,
   input  logic [DUTY_W-1:0] Duty_Input,
   output logic              pwm_out,
   output logic              pwm_out_n,
   output logic              period_strt
);

   localparam int               CNT_W    = $clog2(PERIOD);
   localparam int               CMP_W    = DUTY_W + 1;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD - 1);
   localparam logic [CMP_W-1:0] PERIOD_C = CMP_W'(PERIOD);

   logic [CNT_W-1:0]  count;
   logic [DUTY_W-1:0] duty_sh;
   logic [CMP_W-1:0]  duty_clamp;
   logic              gate, raw, at_last;
   pwm_pair_t         pair;

   assign at_last    = (count == LAST);
   assign duty_clamp = ({1'b0, Duty_Input} > PERIOD_C) ? PERIOD_C : {1'b0, Duty_Input};
   assign raw        = (CMP_W'(count) < {1'b0, duty_sh});

   // Duty and gate both change only at the wrap so a period is never cut short
   // on re-enable; disable is allowed to drop the output immediately.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         count       <= '0;
         duty_sh     <= '0;
         gate        <= 1'b0;
         period_strt <= 1'b0;
      end else begin
         count       <= at_last ? '0 : count + CNT_W'(1);
         period_strt <= (count == '0);
         if (at_last)
            duty_sh <= duty_clamp[DUTY_W-1:0];
         if (!Enable_SW)
            gate <= 1'b0;
         else if (at_last)
            gate <= 1'b1;
      end
   end

`ifdef PWM_DEADTIME_EN
   pwm_deadtime_ins #(
      .DEADTIME (DEADTIME)
   ) u_deadtime (
      .sysclk (sysclk),
      .reset  (reset),
      .raw    (raw),
      .gate   (gate),
      .drv    (pair)
   );
`else
   localparam logic [2:0] DT_UNUSED = 3'(DEADTIME);
   logic unused_deadtime;
   assign unused_deadtime = ^DT_UNUSED;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         pair <= '0;
      end else begin
         pair.hi <= raw & gate;
         pair.lo <= ~raw & gate;
      end
   end
`endif

   assign pwm_out   = pair.hi;
   assign pwm_out_n = pair.lo;

endmodule

// File: tb/tb_pwm_duty_driver.sv
// Directed bench for pwm_duty_driver, PERIOD=64, DUTY_W=7, DEADTIME=2.
module tb_pwm_duty_driver;

   logic       sysclk = 1'b0;
   logic       reset = 1'b1;
   logic       Enable_SW = 1'b0;
   logic [6:0] Duty_Input = 7'd0;
   logic       pwm_out, pwm_out_n, period_strt;
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;

   pwm_duty_driver #(
      .PERIOD   (64),
      .DUTY_W   (7),
      .DEADTIME (2)
   ) dut (
      .sysclk      (sysclk),
      .reset       (reset),
      .Enable_SW   (Enable_SW),
      .Duty_Input  (Duty_Input),
      .pwm_out     (pwm_out),
      .pwm_out_n   (pwm_out_n),
      .period_strt (period_strt)
   );

   always #5 sysclk = ~sysclk;

   task automatic tick();
      @(posedge sysclk);
      #1;
      cyc++;
   endtask

   // After this returns the counter is 0 in the current cycle and cyc==0.
   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge sysclk);
      #1;
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      Enable_SW = 1'b0;
      Duty_Input = 7'd0;
      do_reset(2);
      total++;
      if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
      total++;
      if (pwm_out_n !== 1'b0) begin bad++; $display("FAIL reset_pwm_n got %b want 0", pwm_out_n); end
      total++;
      if (period_strt !== 1'b0) begin bad++; $display("FAIL reset_strt got %b want 0", period_strt); end
      // Disabled: outputs stay low, counter still runs.
      Duty_Input = 7'd30;
      for (int k = 1; k <= 130; k++) begin
         logic es;
         tick();
         es = ((cyc - 1) % 64 == 0);
         total++;
         if (pwm_out !== 1'b0 || pwm_out_n !== 1'b0 || period_strt !== es) begin
            bad++;
            $display("FAIL disabled cyc=%0d got %b%b%b want 00%b", cyc, pwm_out, pwm_out_n, period_strt, es);
         end
      end
   endtask

`ifndef PWM_DEADTIME_EN
   task automatic test_steady();
      int hi2, strt;
      hi2 = 0;
      strt = 0;
      Enable_SW = 1'b1;
      Duty_Input = 7'd16;
      do_reset(2);
      for (int k = 1; k <= 192; k++) begin
         logic ep, en, es;
         int c, p, d;
         tick();
         c = (cyc - 1) % 64;
         p = (cyc - 1) / 64;
         d = (p == 0) ? 0 : 16;
         ep = (p > 0) && (c < d);
         en = (p > 0) && !(c < d);
         es = (c == 0);
         total++;
         if (pwm_out !== ep || pwm_out_n !== en || period_strt !== es) begin
            bad++;
            $display("FAIL steady cyc=%0d got %b%b%b want %b%b%b", cyc, pwm_out, pwm_out_n, period_strt, ep, en, es);
         end
         if (p == 2 && pwm_out === 1'b1) hi2++;
         if (period_strt === 1'b1) strt++;
      end
      total++;
      if (hi2 != 16) begin bad++; $display("FAIL steady_high_count got %0d want 16", hi2); end
      total++;
      if (strt != 3) begin bad++; $display("FAIL steady_strt_count got %0d want 3", strt); end
   endtask

   task automatic test_duty_change();
      int hi1, hi2;
      hi1 = 0;
      hi2 = 0;
      Enable_SW = 1'b1;
      Duty_Input = 7'd16;
      do_reset(2);
      for (int k = 1; k <= 192; k++) begin
         logic ep, en;
         int c, p, d;
         if (cyc == 74) Duty_Input = 7'd40;
         tick();
         c = (cyc - 1) % 64;
         p = (cyc - 1) / 64;
         d = (p == 0) ? 0 : (p == 1) ? 16 : 40;
         ep = (p > 0) && (c < d);
         en = (p > 0) && !(c < d);
         total++;
         if (pwm_out !== ep || pwm_out_n !== en) begin
            bad++;
            $display("FAIL duty_change cyc=%0d got %b%b want %b%b", cyc, pwm_out, pwm_out_n, ep, en);
         end
         if (p == 1 && pwm_out === 1'b1) hi1++;
         if (p == 2 && pwm_out === 1'b1) hi2++;
      end
      total++;
      if (hi1 != 16) begin bad++; $display("FAIL change_cur_period got %0d want 16", hi1); end
      total++;
      if (hi2 != 40) begin bad++; $display("FAIL change_next_period got %0d want 40", hi2); end
   endtask

   task automatic test_extremes();
      int hi[5];
      int edges;
      logic prev;
      for (int i = 0; i < 5; i++) hi[i] = 0;
      edges = 0;
      prev = 1'b0;
      Enable_SW = 1'b1;
      Duty_Input = 7'd0;
      do_reset(2);
      for (int k = 1; k <= 260; k++) begin
         logic ep, en;
         int c, p, d;
         if (cyc == 84) Duty_Input = 7'd64;
         if (cyc == 148) Duty_Input = 7'd100;
         tick();
         c = (cyc - 1) % 64;
         p = (cyc - 1) / 64;
         d = (p <= 1) ? 0 : 64;
         ep = (p > 0) && (c < d);
         en = (p > 0) && !(c < d);
         total++;
         if (pwm_out !== ep || pwm_out_n !== en) begin
            bad++;
            $display("FAIL extremes cyc=%0d got %b%b want %b%b", cyc, pwm_out, pwm_out_n, ep, en);
         end
         if (pwm_out === 1'b1) hi[p]++;
         if (p >= 1 && pwm_out !== prev) edges++;
         prev = pwm_out;
      end
      total++;
      if (hi[1] != 0) begin bad++; $display("FAIL duty0_high got %0d want 0", hi[1]); end
      total++;
      if (hi[2] != 64) begin bad++; $display("FAIL duty64_high got %0d want 64", hi[2]); end
      total++;
      if (hi[3] != 64) begin bad++; $display("FAIL duty100_clamp_high got %0d want 64", hi[3]); end
      total++;
      if (edges != 1) begin bad++; $display("FAIL extremes_edges got %0d want 1", edges); end
   endtask

   task automatic test_enable();
      int hi2, hi3;
      hi2 = 0;
      hi3 = 0;
      Enable_SW = 1'b1;
      Duty_Input = 7'd16;
      do_reset(2);
      for (int k = 1; k <= 256; k++) begin
         logic ep, en, g;
         int j, c, p, d;
         if (cyc == 133) Enable_SW = 1'b0;
         if (cyc == 148) Enable_SW = 1'b1;
         tick();
         j = cyc - 1;
         c = j % 64;
         p = j / 64;
         d = (p == 0) ? 0 : 16;
         g = (j >= 64) && !(j >= 134 && j <= 191);
         ep = g && (c < d);
         en = g && !(c < d);
         total++;
         if (pwm_out !== ep || pwm_out_n !== en) begin
            bad++;
            $display("FAIL enable cyc=%0d got %b%b want %b%b", cyc, pwm_out, pwm_out_n, ep, en);
         end
         if (p == 2 && pwm_out === 1'b1) hi2++;
         if (p == 3 && pwm_out === 1'b1) hi3++;
      end
      total++;
      if (hi2 != 6) begin bad++; $display("FAIL enable_cut_period got %0d want 6", hi2); end
      total++;
      if (hi3 != 16) begin bad++; $display("FAIL enable_resume_period got %0d want 16", hi3); end
   endtask

   task automatic test_reset_mid();
      int hi1;
      hi1 = 0;
      Enable_SW = 1'b1;
      Duty_Input = 7'd16;
      do_reset(2);
      repeat (70) tick();
      total++;
      if (pwm_out !== 1'b1) begin bad++; $display("FAIL mid_pulse_before_reset got %b want 1", pwm_out); end
      reset = 1'b1;
      Duty_Input = 7'd24;
      for (int i = 0; i < 3; i++) begin
         @(posedge sysclk);
         #1;
         total++;
         if (pwm_out !== 1'b0 || pwm_out_n !== 1'b0 || period_strt !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid cycle=%0d got %b%b%b want 000", i, pwm_out, pwm_out_n, period_strt);
         end
      end
      reset = 1'b0;
      cyc = 0;
      for (int k = 1; k <= 192; k++) begin
         logic ep, en, es;
         int c, p, d;
         tick();
         c = (cyc - 1) % 64;
         p = (cyc - 1) / 64;
         d = (p == 0) ? 0 : 24;
         ep = (p > 0) && (c < d);
         en = (p > 0) && !(c < d);
         es = (c == 0);
         total++;
         if (pwm_out !== ep || pwm_out_n !== en || period_strt !== es) begin
            bad++;
            $display("FAIL post_reset cyc=%0d got %b%b%b want %b%b%b", cyc, pwm_out, pwm_out_n, period_strt, ep, en, es);
         end
         if (p == 1 && pwm_out === 1'b1) hi1++;
      end
      total++;
      if (hi1 != 24) begin bad++; $display("FAIL post_reset_duty got %0d want 24", hi1); end
   endtask
`else
   task automatic test_deadtime();
      int hi2;
      hi2 = 0;
      Enable_SW = 1'b1;
      Duty_Input = 7'd16;
      do_reset(2);
      for (int k = 1; k <= 192; k++) begin
         logic eh, el, es;
         int c, p;
         tick();
         c = cyc % 64;
         p = cyc / 64;
         eh = (p >= 1) && (c >= 3) && (c <= 16);
         el = ((p >= 1) && (c >= 19)) || ((p >= 2) && (c == 0));
         es = ((cyc - 1) % 64 == 0);
         total++;
         if (pwm_out !== eh || pwm_out_n !== el || period_strt !== es) begin
            bad++;
            $display("FAIL deadtime cyc=%0d got %b%b%b want %b%b%b", cyc, pwm_out, pwm_out_n, period_strt, eh, el, es);
         end
         total++;
         if (pwm_out === 1'b1 && pwm_out_n === 1'b1) begin
            bad++;
            $display("FAIL overlap cyc=%0d got 11 want not both high", cyc);
         end
         if (p == 2 && pwm_out === 1'b1) hi2++;
      end
      total++;
      if (hi2 != 14) begin bad++; $display("FAIL deadtime_high_count got %0d want 14", hi2); end
   endtask
`endif

   initial begin
      test_reset();
`ifndef PWM_DEADTIME_EN
      test_steady();
      test_duty_change();
      test_extremes();
      test_enable();
      test_reset_mid();
`else
      test_deadtime();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
